go_done_initiator: RTL
======================

# go_done_initiator

Requester side of the go/done handshake used by the team's simple state-machine responders. It accepts a start command carrying a transaction count, then drives `go` to one responder once per transaction and waits for `done`. It counts completed transactions and reports completion or a stalled responder. It sits between control logic (or a bench) and any go/done responder block.

## Interface
- `CNT_W`, default 8: width of the transaction count and of the completed counter.
- `TMO_CYCLES`, default 64: watchdog limit, in cycles, per handshake phase. Legal range is 2..2^16-1. Used only when the watchdog is compiled in.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset. It asserts immediately and is released synchronously to `clk` by the system.
- `start`  in  1: one-cycle command strobe. Sampled in IDLE only.
- `num_req`  in  CNT_W: number of transactions. Latched when `start` is accepted.
- `go`  out  1: request to the responder. Registered.
- `done`  in  1: acknowledge from the responder. Treated as synchronous to `clk`.
- `busy`  out  1: high in every state except IDLE.
- `finished`  out  1: one-cycle pulse when the command ends without error.
- `completed`  out  CNT_W: transactions acknowledged for the current or last command.
- `timeout_err`  out  1: sticky watchdog error flag.

## Operation
- Four-phase return-to-zero handshake:
  - raise `go`;
  - hold `go` until `done`=1 is sampled;
  - drop `go`;
  - wait for `done`=0 before raising `go` for the next transaction.
- States and transitions:
  - **IDLE**: on `start`, latch `num_req` and clear `completed` and `timeout_err`. If `num_req`=0, go to FINISH; otherwise go to ASSERT.
  - **ASSERT** (`go`=1): when `done`=1, increment `completed` and go to RELEASE.
  - **RELEASE** (`go`=0): when `done`=0, go to FINISH if `completed` equals the latched count; otherwise go to ASSERT.
  - **FINISH**: `finished`=1 for exactly one cycle, then go to IDLE.
  - **ERROR**: `go`=0 and `timeout_err`=1, then go to IDLE on the next cycle. No `finished` pulse is produced.
- `start` is ignored while `busy`=1, including in FINISH. `done` is ignored in IDLE.
- `completed` cannot wrap, because it never exceeds the latched count (at most 2^CNT_W-1). It holds its value after the command until the next accepted `start`.
- Reset values: state IDLE, `go`=0, `busy`=0, `finished`=0, `completed`=0, `timeout_err`=0.
- Reset mid-operation forces the reset values immediately, including `go`=0, and discards the latched count.

## Timing
- `start` high at edge N in IDLE: `busy`=1 and `go`=1 after edge N. With `num_req`=0, `finished`=1 after edge N instead.
- `done`=1 sampled at edge M in ASSERT: `go`=0 and `completed` incremented after edge M.
- `done`=0 sampled at edge K in RELEASE:
  - `go`=1 after edge K if transactions remain;
  - otherwise `finished`=1 for one cycle after edge K, and `busy`=0 after edge K+1.
- Minimum cost is 2 cycles per transaction when the responder acknowledges in zero cycles.
- `done` high already at entry to ASSERT is legal. It is accepted on the first edge in ASSERT.

## Configuration
- Macro: `GO_DONE_TIMEOUT_EN`.
- **Defined**:
  - a phase counter clears on every entry to ASSERT or RELEASE and increments on each cycle spent there;
  - if it reaches `TMO_CYCLES` before the exit condition, the next state is ERROR;
  - if the exit condition and the limit coincide on the same edge, the exit condition wins.
- **Not defined**: there is no counter and the block waits indefinitely. `timeout_err` is tied to 0 and ERROR is unreachable.

## Structure
- Shared package `go_done_pkg`: the state enum (IDLE, ASSERT, RELEASE, FINISH, ERROR) and the default `TMO_CYCLES` constant.
- One sub-module, `phase_timer`:
  - inputs: clear, enable;
  - output: expired;
  - instantiated only under `GO_DONE_TIMEOUT_EN`.

## Test plan
Benches pair the block with a behavioural responder whose acknowledge delay is programmable.
- **Three transactions**: `num_req`=3, responder delay 2 cycles. Expect 3 `go` pulses, each dropping 1 cycle after `done` rises. Expect `completed` to step 1,2,3, then one `finished` pulse and `busy`=0.
- **Zero count**: `num_req`=0. Expect `finished` 1 cycle after `start`, no `go`, `completed`=0.
- **Busy and idle filtering**: `start` pulsed during ASSERT is ignored. `done` pulsed in IDLE leaves `go`=0 and `completed` unchanged.
- **Stalled acknowledge (`GO_DONE_TIMEOUT_EN`, `TMO_CYCLES`=64)**: the responder never raises `done`. Expect `timeout_err`=1 and `go`=0 64 cycles after `go` rose, no `finished`, and `busy`=0 one cycle later. The next `start` clears `timeout_err`.
- **Stuck-high acknowledge (`GO_DONE_TIMEOUT_EN`)**: `done` is held high. Expect ERROR from RELEASE after 64 cycles and `completed`=1. Without the macro, the block stays in RELEASE indefinitely.
- **Mid-command reset**: assert `reset` in the 2nd ASSERT of `num_req`=5. Expect `go`, `busy` and `completed` at 0 immediately, without waiting for a clock edge. A `start` after release runs 5 fresh transactions.

Source files
------------

// File: rtl/go_done_pkg.sv
// Shared types for the go/done requester: FSM state encoding and watchdog default.
package go_done_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ASSERT  = 3'd1,
    RELEASE = 3'd2,
    FINISH  = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam int TMO_CYCLES_DEF = 64;

endpackage

// File: rtl/phase_timer.sv
// Per-phase watchdog: counts cycles spent in a handshake phase and flags the limit.
module phase_timer
  import go_done_pkg::*;
#(
  parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [15:0] r_cnt;

  // Expired during the TMO_CYCLES-th cycle of the phase, so the FSM leaves on that edge.
  assign o_expired = i_enable && (r_cnt == 16'(TMO_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/go_done_initiator.sv
// Requester side of a four-phase go/done handshake, issuing num_req transactions per start.
// Optional watchdog compiled in with GO_DONE_TIMEOUT_EN.
module go_done_initiator
  import go_done_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_req,
  output logic             go,
  input  logic             done,
  output logic             busy,
  output logic             finished,
  output logic [CNT_W-1:0] completed,
  output logic             timeout_err,
  output state_t           dbg_state
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_completed;
  logic             r_go;
  logic             w_start_acc;
  logic             w_expired;

  assign w_start_acc = (r_state == IDLE) && start;

  // State register plus the datapath registers that move with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_completed <= '0;
      r_go        <= 1'b0;
    end else begin
      r_state <= w_next;
      r_go    <= (w_next == ASSERT);
      if (w_start_acc) begin
        r_count     <= num_req;
        r_completed <= '0;
      end else if ((r_state == ASSERT) && done) begin
        r_completed <= r_completed + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next = (num_req == '0) ? FINISH : ASSERT;
      end
      ASSERT: begin
        if (done)           w_next = RELEASE;
        else if (w_expired) w_next = ERROR;
      end
      RELEASE: begin
        // r_completed already includes the transaction just acknowledged.
        if (!done)          w_next = (r_completed == r_count) ? FINISH : ASSERT;
        else if (w_expired) w_next = ERROR;
      end
      FINISH:  w_next = IDLE;
      ERROR:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    go        = r_go;
    busy      = (r_state != IDLE);
    finished  = (r_state == FINISH);
    completed = r_completed;
    dbg_state = r_state;
  end

`ifdef GO_DONE_TIMEOUT_EN
  logic w_tmr_enable;
  logic w_tmr_clear;
  logic r_tmo_err;

  assign w_tmr_enable = (r_state == ASSERT) || (r_state == RELEASE);
  assign w_tmr_clear  = (r_state != w_next);

  phase_timer #(
    .TMO_CYCLES(TMO_CYCLES)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (reset),
    .i_clear  (w_tmr_clear),
    .i_enable (w_tmr_enable),
    .o_expired(w_expired)
  );

  // Sticky until the next accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_err <= 1'b0;
    end else if (w_start_acc) begin
      r_tmo_err <= 1'b0;
    end else if (w_next == ERROR) begin
      r_tmo_err <= 1'b1;
    end
  end

  assign timeout_err = r_tmo_err;
`else
  logic w_unused_tmo;

  assign w_unused_tmo = ^TMO_CYCLES;
  assign w_expired    = 1'b0;
  assign timeout_err  = 1'b0;
`endif

endmodule
